// File: rtl/word_to_byte_serializer.sv
// rtl/word_to_byte_serializer.sv - unpacks WORD_W-bit words into a byte stream, byte 0 first
module word_to_byte_serializer #(
  parameter int WORD_W = 64,  // multiple of 8
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_word,
  input  logic [3:0]        in_nbytes,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_pulse,
  output logic              busy,
  output logic [CNT_W-1:0]  bytes_emitted
);

  localparam int BYTES = WORD_W / 8;
  localparam int CW    = $clog2(BYTES + 1);

  // Active entry: the word currently being shifted out, low byte first.
  logic [WORD_W-1:0] act_word_q, act_word_d;
  logic [CW-1:0]     act_cnt_q, act_cnt_d;
  logic              act_last_q, act_last_d;

  // Pending entry: the next word, waiting so there is no bubble between words.
  logic [WORD_W-1:0] pend_word_q, pend_word_d;
  logic [CW-1:0]     pend_cnt_q, pend_cnt_d;
  logic              pend_last_q, pend_last_d;
  logic              pend_valid_q, pend_valid_d;

  logic              err_q, err_d;
  logic [CNT_W-1:0]  emitted_q, emitted_d;

  logic in_fire, out_fire, act_free, nbytes_legal;

  assign in_ready  = !pend_valid_q;
  assign out_valid = (act_cnt_q != '0);
  assign out_data  = out_valid ? act_word_q[7:0] : 8'd0;
  assign out_last  = out_valid && act_last_q && (act_cnt_q == CW'(1));
  assign busy      = out_valid || pend_valid_q;
  assign err_pulse = err_q;
  assign bytes_emitted = emitted_q;

  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  assign act_free     = (act_cnt_q == '0) || (out_fire && (act_cnt_q == CW'(1)));
  // Illegal word sizes are consumed but never stored.
  assign nbytes_legal = (in_nbytes != 4'd0) && ({28'd0, in_nbytes} <= 32'(BYTES));

  // Next-state: drain active, then refill it from pending first, else straight from input.
  always_comb begin
    act_word_d   = act_word_q;
    act_cnt_d    = act_cnt_q;
    act_last_d   = act_last_q;
    pend_word_d  = pend_word_q;
    pend_cnt_d   = pend_cnt_q;
    pend_last_d  = pend_last_q;
    pend_valid_d = pend_valid_q;
    err_d        = 1'b0;
    emitted_d    = emitted_q;

    if (out_fire) begin
      act_word_d = act_word_q >> 8;
      act_cnt_d  = act_cnt_q - CW'(1);
      emitted_d  = emitted_q + CNT_W'(1);
    end

    if (act_free && pend_valid_q) begin
      // in_ready is low here, so no input can arrive this cycle.
      act_word_d   = pend_word_q;
      act_cnt_d    = pend_cnt_q;
      act_last_d   = pend_last_q;
      pend_valid_d = 1'b0;
    end else if (in_fire) begin
      if (!nbytes_legal) begin
        err_d = 1'b1;
      end else if (act_free) begin
        act_word_d = in_word;
        act_cnt_d  = CW'(in_nbytes);
        act_last_d = in_last;
      end else begin
        pend_word_d  = in_word;
        pend_cnt_d   = CW'(in_nbytes);
        pend_last_d  = in_last;
        pend_valid_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any active or pending word outright.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_word_q   <= '0;
      act_cnt_q    <= '0;
      act_last_q   <= 1'b0;
      pend_word_q  <= '0;
      pend_cnt_q   <= '0;
      pend_last_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      err_q        <= 1'b0;
      emitted_q    <= '0;
    end else begin
      act_word_q   <= act_word_d;
      act_cnt_q    <= act_cnt_d;
      act_last_q   <= act_last_d;
      pend_word_q  <= pend_word_d;
      pend_cnt_q   <= pend_cnt_d;
      pend_last_q  <= pend_last_d;
      pend_valid_q <= pend_valid_d;
      err_q        <= err_d;
      emitted_q    <= emitted_d;
    end
  end

endmodule
